seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIG, default 8, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SHOW_CYC, default 1000, clock cycles each digit is driven (>=1).
REQ-003 SHALL have parameter BLANK_CYC, default 16, all-off cycles between digits (anti-ghosting, >=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  scan enable.
REQ-007 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-008 SHALL have port wr_valid  input  1  digit write request.
REQ-009 SHALL have port wr_ready  output  1  write accepted when wr_valid and wr_ready are both 1.
REQ-010 SHALL have port wr_idx  input  3  target digit, 0 = rightmost; idx >= N_DIG ignored but still handshaken.
REQ-011 SHALL have port wr_val  input  4  hex value for digit.
REQ-012 SHALL have port wr_off  input  1  1 = digit blanked.
REQ-013 SHALL have port dig_b  output  4  value to the shared 7-seg decoder's b input.
REQ-014 SHALL have port dig_off  output  1  to the decoder's off input.
REQ-015 SHALL have port an  output  N_DIG  digit enables, active-low, at most one bit low.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-017 SHALL hold two banks of N_DIG entries {val[3:0], off}: shadow (write target) and active (displayed).
REQ-018 SHALL derive all outputs from registered state only; no combinational path from any input to an, dig_b, dig_off, frame_done.
REQ-019 SHALL implement FSM states IDLE, SHOW, BLANK with a cycle counter cnt and digit index idx.
REQ-020 IDLE: an all 1, dig_off=1, dig_b=0; every write goes to both banks; en=1 -> SHOW, idx=0, cnt=0.
REQ-021 SHOW: an[idx]=0, dig_b=active[idx].val, dig_off=active[idx].off or suppressed(idx); after SHOW_CYC cycles -> BLANK, cnt=0.
REQ-022 BLANK: an all 1, dig_off=1; after BLANK_CYC cycles -> SHOW, idx=idx+1, wrapping N_DIG-1 -> 0.
REQ-023 On the BLANK->SHOW transition with idx wrapping to 0, SHALL copy shadow to active in that same edge and assert frame_done for exactly that one following cycle.
REQ-024 wr_ready SHALL be 0 only in the cycle where the commit of REQ-023 is being taken; otherwise 1, including in IDLE.
REQ-025 Write and commit never coincide; a write accepted in the cycle before commit SHALL appear in the committed frame.
REQ-026 en=0 in any state SHALL force IDLE on the next edge, idx=0, cnt=0, no frame_done; shadow content SHALL be copied to active on that edge.
REQ-027 suppressed(i) SHALL be 1 when lz_en=1, i>0, and every digit j>=i has val=0 or off=1; digit 0 is never suppressed.
REQ-028 Full frame length SHALL be N_DIG*(SHOW_CYC+BLANK_CYC) cycles; frame_done period equals this while en=1.
REQ-029 Multiple writes to the same idx within a frame: last accepted write wins.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, idx=0, cnt=0, both banks {val=0, off=1}, an all 1, dig_b=0, dig_off=1, frame_done=0, wr_ready=1.
REQ-031 Reset asserted mid-SHOW SHALL blank all digits without waiting for a clock edge; after release, scan restarts only with en=1.

Verification (N_DIG=8, SHOW_CYC=4, BLANK_CYC=1)
REQ-032 Reset then en=1, write idx0=5 in IDLE first -> an=8'hFE for 4 cycles, dig_b=5, dig_off=0; then an=8'hFF for 1 cycle; then an=8'hFD with dig_off=1.
REQ-033 en held 1 for 100 cycles -> frame_done pulses every 40 cycles, exactly one cycle wide, an never has two bits low.
REQ-034 During scan write idx3=A mid-frame -> digit 3 shows old value until commit, shows A after next frame_done; wr_ready=0 only on commit cycles.
REQ-035 lz_en=1, digits 7..0 = 0,0,0,1,0,0,0,0 all on -> digits 7..5 dig_off=1, digits 4..0 dig_off=0; lz_en=1 with all zeros -> only digit 0 lit.
REQ-036 rst pulsed during SHOW of idx 2 -> an=8'hFF and dig_off=1 asynchronously; after release with en=1, scan restarts at idx 0 with all digits off.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//    Time-multiplexed scan controller for N_DIG seven-segment digits sharing
//    one decoder. Each digit is driven for SHOW_CYC cycles, followed by
//    BLANK_CYC all-off cycles to avoid ghosting. Writes land in a shadow bank
//    that is copied to the displayed (active) bank once per frame, so a frame
//    never shows a half-updated number.
//
// Ports
//    clk        : single clock, all state on rising edge
//    rst        : asynchronous active-high reset
//    en         : scan enable (0 returns to IDLE)
//    lz_en      : leading-zero suppression enable
//    wr_valid   : digit write request
//    wr_ready   : write accepted when wr_valid && wr_ready
//    wr_idx     : target digit, 0 = rightmost, >= N_DIG ignored
//    wr_val     : hex value for the digit
//    wr_off     : 1 = digit blanked
//    dig_b      : value to the shared decoder
//    dig_off    : decoder blank input
//    an         : active-low digit enables, at most one low
//    frame_done : one-cycle pulse at the start of each new frame
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int N_DIG     = 8,
   parameter int SHOW_CYC  = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             lz_en,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [2:0]       wr_idx,
   input  logic [3:0]       wr_val,
   input  logic             wr_off,
   output logic [3:0]       dig_b,
   output logic             dig_off,
   output logic [N_DIG-1:0] an,
   output logic             frame_done
);

   localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [2:0]    IDX_LAST   = 3'(N_DIG - 1);
   localparam logic [3:0]    NDIG4      = 4'(N_DIG);

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_idx;
   logic [3:0]       r_shVal [N_DIG];
   logic [N_DIG-1:0] r_shOff;
   logic [3:0]       r_acVal [N_DIG];
   logic [N_DIG-1:0] r_acOff;
   logic [N_DIG-1:0] r_an;
   logic [3:0]       r_digB;
   logic             r_digOff;
   logic             r_frameDone;

   logic             w_commit;
   logic             w_wrHit;
   logic [3:0]       w_shValNext [N_DIG];
   logic [N_DIG-1:0] w_shOffNext;
   logic [3:0]       w_acValNext [N_DIG];
   logic [N_DIG-1:0] w_acOffNext;
   state_t           w_stateNext;
   logic [CW-1:0]    w_cntNext;
   logic [2:0]       w_idxNext;
   logic             w_acLoad;
   logic             w_fdNext;
   logic [N_DIG-1:0] w_lead;
   logic             w_run;
   logic             w_supp;

   // The commit cycle is the last blank cycle after the final digit; writes
   // are stalled there so the copy into the active bank is never racing one.
   always_comb begin
      w_commit = (r_state == BLANK) && (r_cnt == BLANK_LAST) && (r_idx == IDX_LAST);
      wr_ready = ~w_commit;
      w_wrHit  = wr_valid && wr_ready && ({1'b0, wr_idx} < NDIG4);
   end

   // Shadow bank as it will be after this cycle's write. Anything that loads
   // the active bank takes this value, so an IDLE write reaches both banks
   // and a write alongside a disable is not lost.
   always_comb begin
      for (int i = 0; i < N_DIG; i++) begin
         w_shValNext[i] = r_shVal[i];
      end
      w_shOffNext = r_shOff;
      if (w_wrHit) begin
         w_shValNext[wr_idx] = wr_val;
         w_shOffNext[wr_idx] = wr_off;
      end
   end

   // Scan sequencing: IDLE -> SHOW(idx) -> BLANK -> SHOW(idx+1) ..., with
   // the active bank reloaded on frame wrap, on entry from IDLE and on disable.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_idxNext   = r_idx;
      w_acLoad    = 1'b0;
      w_fdNext    = 1'b0;
      if (!en) begin
         w_stateNext = IDLE;
         w_cntNext   = '0;
         w_idxNext   = '0;
         w_acLoad    = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               w_stateNext = SHOW;
               w_cntNext   = '0;
               w_idxNext   = '0;
               w_acLoad    = 1'b1;
            end
            SHOW: begin
               if (r_cnt == SHOW_LAST) begin
                  w_stateNext = BLANK;
                  w_cntNext   = '0;
               end else begin
                  w_cntNext = r_cnt + 1'b1;
               end
            end
            BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  w_stateNext = SHOW;
                  w_cntNext   = '0;
                  if (r_idx == IDX_LAST) begin
                     w_idxNext = '0;
                     w_acLoad  = 1'b1;
                     w_fdNext  = 1'b1;
                  end else begin
                     w_idxNext = r_idx + 1'b1;
                  end
               end else begin
                  w_cntNext = r_cnt + 1'b1;
               end
            end
            default: begin
               w_stateNext = IDLE;
               w_cntNext   = '0;
               w_idxNext   = '0;
            end
         endcase
      end
   end

   // Active bank next value and leading-zero detection on it. w_lead[i] is
   // set when digit i and every digit to its left are zero or blanked.
   always_comb begin
      for (int i = 0; i < N_DIG; i++) begin
         w_acValNext[i] = w_acLoad ? w_shValNext[i] : r_acVal[i];
      end
      w_acOffNext = w_acLoad ? w_shOffNext : r_acOff;
      w_run  = 1'b1;
      w_lead = '0;
      for (int i = N_DIG - 1; i >= 0; i--) begin
         w_run     = w_run && ((w_acValNext[i] == 4'd0) || w_acOffNext[i]);
         w_lead[i] = w_run;
      end
      w_supp = lz_en && (w_idxNext != 3'd0) && w_lead[w_idxNext];
   end

   // All state and outputs. Outputs are computed from next-state so they
   // line up with the state they describe and carry no input-to-output path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         for (int i = 0; i < N_DIG; i++) begin
            r_shVal[i] <= 4'd0;
            r_acVal[i] <= 4'd0;
         end
         r_shOff     <= '1;
         r_acOff     <= '1;
         r_an        <= '1;
         r_digB      <= 4'd0;
         r_digOff    <= 1'b1;
         r_frameDone <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
         r_idx   <= w_idxNext;
         for (int i = 0; i < N_DIG; i++) begin
            r_shVal[i] <= w_shValNext[i];
            r_acVal[i] <= w_acValNext[i];
         end
         r_shOff     <= w_shOffNext;
         r_acOff     <= w_acOffNext;
         r_frameDone <= w_fdNext;
         if (w_stateNext == SHOW) begin
            r_an     <= ~(N_DIG'(1) << w_idxNext);
            r_digB   <= w_acValNext[w_idxNext];
            r_digOff <= w_acOffNext[w_idxNext] | w_supp;
         end else begin
            r_an     <= '1;
            r_digB   <= 4'd0;
            r_digOff <= 1'b1;
         end
      end
   end

   assign an         = r_an;
   assign dig_b      = r_digB;
   assign dig_off    = r_digOff;
   assign frame_done = r_frameDone;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//    Self-checking bench for seg_scan_ctrl with N_DIG=8, SHOW_CYC=4,
//    BLANK_CYC=1. The reference model tracks the displayed position as a
//    cycle offset into the frame and derives digit and show/blank phase by
//    division, independent of any state machine encoding.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   localparam int ND = 8;
   localparam int SC = 4;
   localparam int BC = 1;
   localparam int SLOT = SC + BC;
   localparam int FR = ND * SLOT;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          lz_en;
   logic          wr_valid;
   logic          wr_ready;
   logic [2:0]    wr_idx;
   logic [3:0]    wr_val;
   logic          wr_off;
   logic [3:0]    dig_b;
   logic          dig_off;
   logic [ND-1:0] an;
   logic          frame_done;

   int nVec  = 0;
   int nMiss = 0;

   // Reference model state
   logic [3:0] mSh    [ND];
   logic       mShOff [ND];
   logic [3:0] mAc    [ND];
   logic       mAcOff [ND];
   bit         mRun;
   int         mT;
   bit         mFd;
   logic       mLz;

   seg_scan_ctrl #(.N_DIG(ND), .SHOW_CYC(SC), .BLANK_CYC(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .lz_en      (lz_en),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_idx     (wr_idx),
      .wr_val     (wr_val),
      .wr_off     (wr_off),
      .dig_b      (dig_b),
      .dig_off    (dig_off),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMiss++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < ND; i++) begin
         mSh[i] = 4'd0; mShOff[i] = 1'b1;
         mAc[i] = 4'd0; mAcOff[i] = 1'b1;
      end
      mRun = 1'b0; mT = 0; mFd = 1'b0; mLz = 1'b0;
   endtask

   task automatic copyBank();
      for (int i = 0; i < ND; i++) begin
         mAc[i] = mSh[i]; mAcOff[i] = mShOff[i];
      end
   endtask

   function automatic bit suppressed(input int d);
      if (!mLz || d == 0) return 1'b0;
      for (int j = d; j < ND; j++) begin
         if (mAc[j] != 4'd0 && !mAcOff[j]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Advance the model across one rising edge with the inputs that were applied.
   task automatic modelEdge(input logic e, input logic l, input logic acc,
                            input logic [2:0] ix, input logic [3:0] vl, input logic o);
      mLz = l;
      if (acc) begin
         mSh[ix] = vl; mShOff[ix] = o;
      end
      if (!e) begin
         mRun = 1'b0; mT = 0; mFd = 1'b0; copyBank();
      end else if (!mRun) begin
         mRun = 1'b1; mT = 0; mFd = 1'b0; copyBank();
      end else begin
         mT++;
         mFd = ((mT % FR) == 0);
         if (mFd) copyBank();
      end
   endtask

   task automatic checkOutput();
      int p, d;
      bit showing;
      logic [ND-1:0] expAn;
      logic [3:0]    expB;
      logic          expOff;
      p = mT % FR;
      d = p / SLOT;
      showing = mRun && ((p % SLOT) < SC);
      if (showing) begin
         expAn  = ~(ND'(1) << d);
         expB   = mAc[d];
         expOff = mAcOff[d] | suppressed(d);
      end else begin
         expAn  = '1;
         expB   = 4'd0;
         expOff = 1'b1;
      end
      compare("an", 32'(an), 32'(expAn));
      compare("dig_b", 32'(dig_b), 32'(expB));
      compare("dig_off", 32'(dig_off), 32'(expOff));
      compare("frame_done", 32'(frame_done), 32'(mFd));
   endtask

   // One clock of stimulus, called at the falling edge.
   task automatic applyStimulus(input logic e, input logic l, input logic v,
                                input logic [2:0] ix, input logic [3:0] vl, input logic o);
      logic expReady;
      en = e; lz_en = l; wr_valid = v; wr_idx = ix; wr_val = vl; wr_off = o;
      expReady = !(mRun && ((mT % FR) == FR - 1));
      #1;
      compare("wr_ready", 32'(wr_ready), 32'(expReady));
      @(posedge clk);
      modelEdge(e, l, v && expReady, ix, vl, o);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idleCycles(input int n, input logic e, input logic l);
      for (int i = 0; i < n; i++) applyStimulus(e, l, 1'b0, 3'd0, 4'd0, 1'b0);
   endtask

   initial begin
      logic lzR;
      int guard;
      rst = 1'b1; en = 1'b0; lz_en = 1'b0;
      wr_valid = 1'b0; wr_idx = 3'd0; wr_val = 4'd0; wr_off = 1'b0;
      resetModel();
      @(negedge clk);
      @(negedge clk);
      compare("rst_an", 32'(an), 32'hFF);
      compare("rst_dig_off", 32'(dig_off), 32'd1);
      compare("rst_dig_b", 32'(dig_b), 32'd0);
      compare("rst_frame_done", 32'(frame_done), 32'd0);
      compare("rst_wr_ready", 32'(wr_ready), 32'd1);
      rst = 1'b0;
      idleCycles(2, 1'b0, 1'b0);

      // First scan: write digit 0 = 5 while still idle, enabling on the same cycle
      $display("[TB] first scan with digit0=5");
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 4'd5, 1'b0);
      compare("first_an", 32'(an), 32'hFE);
      compare("first_dig_b", 32'(dig_b), 32'd5);
      compare("first_dig_off", 32'(dig_off), 32'd0);

      // Continuous scan for 100 cycles
      idleCycles(100, 1'b1, 1'b0);

      // Mid-frame write of digit 3 = A; old value stays until the commit
      $display("[TB] mid-frame write digit3=A");
      guard = 0;
      while ((mT % FR) != 7 && guard < 100) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
         guard++;
      end
      compare("align_guard", 32'(guard < 100), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, 4'hA, 1'b0);
      idleCycles(2 * FR, 1'b1, 1'b0);

      // Leading-zero suppression: digits 7..0 = 0,0,0,1,0,0,0,0
      $display("[TB] leading-zero suppression");
      idleCycles(1, 1'b0, 1'b1);
      for (int i = 0; i < ND; i++)
         applyStimulus(1'b0, 1'b1, 1'b1, 3'(i), (i == 4) ? 4'd1 : 4'd0, 1'b0);
      idleCycles(FR + 2, 1'b1, 1'b1);
      idleCycles(1, 1'b0, 1'b1);
      for (int i = 0; i < ND; i++)
         applyStimulus(1'b0, 1'b1, 1'b1, 3'(i), 4'd0, 1'b0);
      idleCycles(FR + 2, 1'b1, 1'b1);

      // Randomized traffic with occasional disables and lz_en changes
      $display("[TB] randomized traffic");
      lzR = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 49) == 0) lzR = ~lzR;
         applyStimulus(($urandom_range(0, 149) != 0), lzR,
                       ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)),
                       4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      end

      // Asynchronous reset while digit 2 is shown
      $display("[TB] async reset during digit 2");
      idleCycles(1, 1'b0, 1'b0);
      guard = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
      while ((mT % FR) != 2 * SLOT + 1 && guard < 100) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
         guard++;
      end
      compare("align_guard2", 32'(guard < 100), 32'd1);
      compare("pre_rst_an", 32'(an), 32'hFB);
      #2 rst = 1'b1;
      #1;
      compare("async_an", 32'(an), 32'hFF);
      compare("async_dig_off", 32'(dig_off), 32'd1);
      compare("async_dig_b", 32'(dig_b), 32'd0);
      compare("async_wr_ready", 32'(wr_ready), 32'd1);
      resetModel();
      @(negedge clk);
      rst = 1'b0;
      idleCycles(FR + 5, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
